// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding SRAM
// request/response handshake and applies branch/flush redirects.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int unsigned STALL_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [31:0]        new_pc,
    input  logic               br_e,
    input  logic [31:0]        br_addr,
    output logic               inst_req,
    output logic [31:0]        inst_addr,
    input  logic               inst_addr_ok,
    input  logic               inst_data_ok,
    input  logic [31:0]        inst_rdata,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_inst,
    output logic               stallreq_for_if
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] br_target, br_target_n;
    logic [31:0] inst_reg, inst_reg_n;
    logic        br_pend, br_pend_n;
    logic [31:0] next_pc;
    logic        handoff;
    logic        unused_stall;

    // Only stall[1] matters to this stage; the remaining bits belong to other stages.
    assign unused_stall = ^stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            br_pend   <= 1'b0;
            br_target <= '0;
            inst_reg  <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            br_pend   <= br_pend_n;
            br_target <= br_target_n;
            inst_reg  <= inst_reg_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        br_pend_n   = br_pend;
        br_target_n = br_target;
        inst_reg_n  = inst_reg;
        handoff     = (state == HOLD) && !stall[1];
        next_pc     = br_e ? br_addr : (br_pend ? br_target : pc + 32'd4);

        if (flush) begin
            // An accepted but unanswered request must be drained in DROP before re-issuing.
            pc_n       = new_pc;
            br_pend_n  = 1'b0;
            inst_reg_n = '0;
            case (state)
                IDLE:    state_n = IDLE;
                REQ:     state_n = inst_addr_ok ? DROP : REQ;
                WAIT:    state_n = inst_data_ok ? REQ : DROP;
                DROP:    state_n = inst_data_ok ? REQ : DROP;
                HOLD:    state_n = REQ;
                default: state_n = IDLE;
            endcase
        end else begin
            // Branch seen while the delay slot is still held: remember it for the handoff.
            if (br_e && !handoff) begin
                br_pend_n   = 1'b1;
                br_target_n = br_addr;
            end
            case (state)
                IDLE: state_n = REQ;
                REQ:  if (inst_addr_ok) state_n = WAIT;
                WAIT: begin
                    if (inst_data_ok) begin
                        inst_reg_n = inst_rdata;
                        state_n    = HOLD;
                    end
                end
                DROP: if (inst_data_ok) state_n = REQ;
                HOLD: begin
                    if (handoff) begin
                        pc_n      = next_pc;
                        br_pend_n = 1'b0;
                        state_n   = REQ;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        inst_req        = (state == REQ);
        inst_addr       = pc;
        if_pc           = '0;
        if_inst         = '0;
        stallreq_for_if = 1'b1;
        if (state == HOLD) begin
            if_pc           = pc;
            if_inst         = inst_reg;
            stallreq_for_if = 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: behavioural SRAM with programmable latency,
// address and delivered-instruction scoreboards.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        br_e;
    logic [31:0] br_addr;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_for_if;

    if_fetch #(.RESET_PC(32'hBFC0_0000), .STALL_W(6)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .br_e(br_e), .br_addr(br_addr), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .if_pc(if_pc), .if_inst(if_inst), .stallreq_for_if(stallreq_for_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_t;

    logic [31:0] exp_addr[$];
    fetch_t      exp_data[$];

    int ntests = 0;
    int nfail  = 0;

    // SRAM model state
    bit          pend = 1'b0;
    bit          acc_en = 1'b0;
    bit          accepted_ev = 1'b0;
    int          cnt = 0;
    int          lat = 0;
    logic [31:0] paddr = '0;
    logic [31:0] acc_addr = '0;

    // Output monitor state
    bit          prev_hold = 1'b0;
    bit          chk_tput = 1'b0;
    int          deliveries = 0;
    int          cyc = 0;
    int          last_del_cyc = 0;
    logic [31:0] last_pc = '0;
    logic [31:0] last_inst = '0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h8000_1008) return 32'h2401_0001;
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_fetch(input logic [31:0] a);
        fetch_t f;
        f.pc   = a;
        f.inst = mem(a);
        exp_addr.push_back(a);
        exp_data.push_back(f);
    endtask

    task automatic tick();
        fetch_t f;
        bit     hold;
        @(posedge clk);
        #1;
        cyc++;
        // SRAM: retire what the edge just sampled, then drive this cycle's handshake
        if (inst_data_ok) pend = 1'b0;
        accepted_ev = 1'b0;
        if (inst_addr_ok) begin
            accepted_ev = 1'b1;
            pend  = 1'b1;
            paddr = acc_addr;
            cnt   = lat;
            if (exp_addr.size() == 0) begin
                ntests++;
                nfail++;
                $error("FAIL unexpected_req observed=%h expected=none", acc_addr);
            end else begin
                check("inst_addr", acc_addr, exp_addr.pop_front());
            end
        end
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        if (pend) begin
            if (cnt == 0) begin
                inst_data_ok = 1'b1;
                inst_rdata   = mem(paddr);
            end else begin
                cnt--;
            end
        end else if (inst_req === 1'b1 && acc_en) begin
            inst_addr_ok = 1'b1;
            acc_addr     = inst_addr;
        end
        // Monitor
        hold = (stallreq_for_if === 1'b0);
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && stall[1] && !flush) begin
                check("stall_hold_pc", if_pc, last_pc);
                check("stall_hold_inst", if_inst, last_inst);
                check("stall_hold_req", {31'b0, inst_req}, 32'd0);
                check("stall_hold_stallreq", {31'b0, stallreq_for_if}, 32'd0);
            end else begin
                if (prev_hold) check("hold_one_cycle", {31'b0, stallreq_for_if}, 32'd1);
                if (hold) begin
                    deliveries++;
                    if (exp_data.size() == 0) begin
                        ntests++;
                        nfail++;
                        $error("FAIL unexpected_delivery observed=%h/%h expected=none", if_pc, if_inst);
                    end else begin
                        f = exp_data.pop_front();
                        check("deliver_pc", if_pc, f.pc);
                        check("deliver_inst", if_inst, f.inst);
                    end
                    check("hold_req", {31'b0, inst_req}, 32'd0);
                    if (chk_tput && deliveries > 1) check("throughput", cyc - last_del_cyc, 32'd3);
                    last_del_cyc = cyc;
                    last_pc      = if_pc;
                    last_inst    = if_inst;
                end else begin
                    check("nohold_pc", if_pc, 32'd0);
                    check("nohold_inst", if_inst, 32'd0);
                end
            end
            prev_hold = hold;
        end
    endtask

    task automatic wait_deliv(input int n);
        int k = 0;
        while (deliveries < n && k < 300) begin
            tick();
            k++;
        end
        check("deliv_timeout", deliveries, n);
    endtask

    task automatic wait_accept();
        int k = 0;
        do begin
            tick();
            k++;
        end while (!accepted_ev && k < 300);
        check("accept_timeout", {31'b0, accepted_ev}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0; br_e = 1'b0; br_addr = '0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
        tick();
        tick();
        check("rst_req", {31'b0, inst_req}, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_inst", if_inst, 32'd0);
        check("rst_stallreq", {31'b0, stallreq_for_if}, 32'd1);
        check("rst_addr", inst_addr, 32'hBFC0_0000);

        // Sequential fetch with a 0-wait SRAM
        acc_en = 1'b1;
        for (int unsigned i = 0; i < 5; i++) push_fetch(32'hBFC0_0000 + 4 * i);
        rst = 1'b0;
        chk_tput = 1'b1;
        wait_deliv(3);
        chk_tput = 1'b0;

        // Stall while holding BFC00010
        wait_deliv(5);
        stall = 6'b000010;
        for (int unsigned i = 0; i < 4; i++) tick();
        for (int unsigned i = 5; i < 9; i++) push_fetch(32'hBFC0_0000 + 4 * i);
        stall = '0;

        // Branch during stalled delay slot at BFC00020
        wait_deliv(9);
        stall = 6'b000010; br_e = 1'b1; br_addr = 32'h8000_1000;
        tick();
        br_e = 1'b0; br_addr = '0;
        tick();
        push_fetch(32'h8000_1000);
        push_fetch(32'h8000_1004);
        stall = '0;
        wait_deliv(11);

        // Flush while waiting on a slow response; the late data must be dropped
        lat = 3;
        exp_addr.push_back(32'h8000_1008);
        wait_accept();
        flush = 1'b1; new_pc = 32'hBFC0_0380;
        lat = 0;
        push_fetch(32'hBFC0_0380);
        tick();
        flush = 1'b0;
        check("drop_req", {31'b0, inst_req}, 32'd0);
        wait_deliv(12);

        // Flush and branch together in HOLD: flush wins, branch forgotten
        flush = 1'b1; new_pc = 32'hBFC0_0400; br_e = 1'b1; br_addr = 32'h8000_2000;
        push_fetch(32'hBFC0_0400);
        push_fetch(32'hBFC0_0404);
        tick();
        flush = 1'b0; br_e = 1'b0; br_addr = '0;
        wait_deliv(14);

        // Reset in the middle of WAIT
        lat = 3;
        exp_addr.push_back(32'hBFC0_0408);
        wait_accept();
        rst = 1'b1;
        tick();
        check("midrst_req", {31'b0, inst_req}, 32'd0);
        check("midrst_if_pc", if_pc, 32'd0);
        check("midrst_if_inst", if_inst, 32'd0);
        check("midrst_stallreq", {31'b0, stallreq_for_if}, 32'd1);
        rst = 1'b0;
        lat = 0;
        push_fetch(32'hBFC0_0000);
        wait_deliv(15);

        check("addr_queue_empty", exp_addr.size(), 32'd0);
        check("data_queue_empty", exp_data.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC, runs a single-outstanding request/response handshake to the instruction SRAM, and applies branch and flush redirects. It presents a stable (if_pc, if_inst) pair that the IF/ID register captures when not stalled, and it raises a stall request while no fetched instruction is available.

Parameters:
RESET_PC, 32'hBFC0_0000, first fetch address after reset
STALL_W, 6, width of controller stall vector; stall[1] freezes PC/IF

Ports:
clk  in  1  clock
rst  in  1  reset
stall  in  STALL_W  controller stall vector; only stall[1] used
flush  in  1  exception/ERET redirect, highest priority
new_pc  in  32  flush target
br_e  in  1  branch taken, one-cycle pulse from ID
br_addr  in  32  branch target
inst_req  out  1  SRAM request valid
inst_addr  out  32  SRAM request address (= pc)
inst_addr_ok  in  1  request accepted this cycle
inst_data_ok  in  1  read data valid this cycle
inst_rdata  in  32  read data
if_pc  out  32  PC of held instruction, 0 when none
if_inst  out  32  held instruction, 0 when none
stallreq_for_if  out  1  high while no valid instruction held

Behaviour:
- Reset (rst=1 at posedge): state<=IDLE, pc<=RESET_PC, br_pend<=0, inst_reg<=0. inst_req=0, if_pc=0, if_inst=0, stallreq_for_if=1. Reset overrides an outstanding SRAM transaction; the response is not tracked.
- States: IDLE, REQ, WAIT, DROP, HOLD. Only HOLD is valid.
- IDLE: -> REQ next cycle.
- REQ: inst_req=1, inst_addr=pc. On inst_addr_ok -> WAIT.
- WAIT: inst_req=0. On inst_data_ok: inst_reg<=inst_rdata -> HOLD.
- HOLD: if_pc=pc, if_inst=inst_reg, stallreq_for_if=0. Handoff occurs when stall[1]=0: pc<=next_pc, clear br_pend -> REQ. With stall[1]=1: hold outputs unchanged and issue no request.
- Outside HOLD: if_pc=0, if_inst=0, stallreq_for_if=1. All three outputs are combinational from the registered state.
- next_pc: br_e this cycle ? br_addr : br_pend ? br_target : pc+4. Addition wraps mod 2^32.
- br_e when not handing off: br_pend<=1, br_target<=br_addr. The instruction currently held (delay slot) is NOT cancelled.
- Flush has priority over br_e, handoff and SRAM events. It sets pc<=new_pc, br_pend<=0, inst_reg<=0, and the next state depends on the current one:
  - IDLE: stays IDLE.
  - HOLD, or REQ without addr_ok: -> REQ with the new pc.
  - REQ with addr_ok, or WAIT without data_ok: -> DROP.
  - WAIT with data_ok: the data is discarded -> REQ.
  - DROP: stays DROP, unless data_ok -> REQ.
- DROP: inst_req=0. Wait for inst_data_ok, discard the data -> REQ at the current pc.
- At most one outstanding request; no new request until data_ok is seen for the previous one.
- Throughput with a 0-wait SRAM (addr_ok in REQ, data_ok on the next cycle) and no stall: one instruction per 3 cycles (REQ, WAIT, HOLD).
- inst_addr is driven = pc in every state. Only inst_req qualifies it.

Test Plan:
1. Reset, 0-wait SRAM, stall=0 -> inst_addr sequence BFC00000, BFC00004, BFC00008; each instruction appears on if_pc/if_inst for exactly one HOLD cycle; stallreq_for_if low only in HOLD.
2. In HOLD with pc=BFC00010, hold stall[1]=1 for 4 cycles -> if_pc=BFC00010 and if_inst unchanged, inst_req=0 throughout; release -> next inst_addr BFC00014.
3. br_e=1, br_addr=80001000 while HOLD at pc=BFC00020 with stall[1]=1; release 2 cycles later -> delay-slot BFC00020 delivered, next inst_addr=80001000 (not BFC00024), br_pend cleared.
4. flush=1, new_pc=BFC00380 in WAIT with data_ok delayed 3 cycles -> DROP; late data (e.g. 0x24010001) never appears on if_inst; next request inst_addr=BFC00380.
5. flush and br_e in the same cycle in HOLD -> inst_addr=new_pc, br_pend=0; br_addr ignored.
6. rst asserted mid-WAIT -> all outputs 0 next cycle, stallreq_for_if=1, first request after IDLE at RESET_PC.
